// File: rtl/execute_cc_stage_if.sv
// Execute-to-memory bus for execute_cc_stage: execute-side inputs and the E->M register outputs.
interface execute_cc_stage_if #(parameter int W = 64);
    logic         e_valid;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] alu_out;
    logic [2:0]   alu_cc;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;

    logic         M_valid;
    logic [3:0]   M_icode;
    logic         M_cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output e_valid, e_icode, e_ifun, alu_out, alu_cc, e_valA, e_dstE, e_dstM,
        input  M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  e_valid, e_icode, e_ifun, alu_out, alu_cc, e_valA, e_dstE, e_dstM,
        output M_valid, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/execute_cc_stage.sv
// Y86-64 execute back end: CC register, jump/cmov condition evaluation and E->M pipeline register.
// Optional CC update counter is built when CC_UPD_CNT_EN is defined; otherwise cc_upd_cnt reads 0.
module execute_cc_stage #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    execute_cc_stage_if.slave eb,
    input  logic        set_cc_block,
    input  logic        m_stall,
    input  logic        m_bubble,
    output logic [2:0]  cc,
    output logic        e_cnd,
    output logic [31:0] cc_upd_cnt
);

    localparam logic [3:0] ICODE_NOP  = 4'h1;
    localparam logic [3:0] ICODE_CMOV = 4'h2;
    localparam logic [3:0] ICODE_OPQ  = 4'h6;
    localparam logic [3:0] ICODE_JXX  = 4'h7;
    localparam logic [3:0] REG_NONE   = 4'hF;

    logic cc_upd;
    logic zf, sf, of;
    logic cond;

    // A stalled M stage means the OPq will re-execute, so it must not commit flags yet.
    assign cc_upd = eb.e_valid && (eb.e_icode == ICODE_OPQ) && !set_cc_block && !m_stall;
    assign {zf, sf, of} = cc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc <= 3'b100;
        end else if (cc_upd) begin
            cc <= eb.alu_cc;
        end
    end

    always_comb begin
        cond = 1'b0;
        case (eb.e_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf ^ of) | zf;
            4'h2:    cond = sf ^ of;
            4'h3:    cond = zf;
            4'h4:    cond = !zf;
            4'h5:    cond = !(sf ^ of);
            4'h6:    cond = !(sf ^ of) && !zf;
            default: cond = 1'b0;
        endcase
        e_cnd = cond && eb.e_valid && (eb.e_icode == ICODE_CMOV || eb.e_icode == ICODE_JXX);
    end

    // Bubble beats stall so a squashed instruction never lingers in M.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eb.M_valid <= 1'b0;
            eb.M_icode <= ICODE_NOP;
            eb.M_cnd   <= 1'b0;
            eb.M_valE  <= {W{1'b0}};
            eb.M_valA  <= {W{1'b0}};
            eb.M_dstE  <= REG_NONE;
            eb.M_dstM  <= REG_NONE;
        end else if (m_bubble) begin
            eb.M_valid <= 1'b0;
            eb.M_icode <= ICODE_NOP;
            eb.M_cnd   <= 1'b0;
            eb.M_valE  <= {W{1'b0}};
            eb.M_valA  <= {W{1'b0}};
            eb.M_dstE  <= REG_NONE;
            eb.M_dstM  <= REG_NONE;
        end else if (!m_stall) begin
            eb.M_valid <= eb.e_valid;
            eb.M_icode <= eb.e_icode;
            eb.M_cnd   <= e_cnd;
            eb.M_valE  <= eb.alu_out;
            eb.M_valA  <= eb.e_valA;
            eb.M_dstE  <= (eb.e_icode == ICODE_CMOV && !e_cnd) ? REG_NONE : eb.e_dstE;
            eb.M_dstM  <= eb.e_dstM;
        end
    end

`ifdef CC_UPD_CNT_EN
    // Saturating count of committed flag updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_upd_cnt <= 32'h0;
        end else if (cc_upd && cc_upd_cnt != 32'hFFFF_FFFF) begin
            cc_upd_cnt <= cc_upd_cnt + 32'h1;
        end
    end
`else
    assign cc_upd_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_execute_cc_stage.sv
// Directed testbench for execute_cc_stage; counter expectations follow CC_UPD_CNT_EN.
module tb_execute_cc_stage;

`ifdef CC_UPD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        set_cc_block;
    logic        m_stall;
    logic        m_bubble;
    logic [2:0]  cc;
    logic        e_cnd;
    logic [31:0] cc_upd_cnt;

    int tests = 0;
    int fails = 0;
    int upd_applied = 0;
    logic [31:0] exp_cnt;

    execute_cc_stage_if #(.W(64)) eb ();

    execute_cc_stage #(.W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .eb           (eb),
        .set_cc_block (set_cc_block),
        .m_stall      (m_stall),
        .m_bubble     (m_bubble),
        .cc           (cc),
        .e_cnd        (e_cnd),
        .cc_upd_cnt   (cc_upd_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [3:0] icode, input logic [3:0] ifun,
                          input logic [63:0] valE, input logic [2:0] acc,
                          input logic [3:0] dstE, input logic [3:0] dstM);
        eb.e_valid = v;
        eb.e_icode = icode;
        eb.e_ifun  = ifun;
        eb.alu_out = valE;
        eb.alu_cc  = acc;
        eb.e_valA  = valE ^ 64'hA5;
        eb.e_dstE  = dstE;
        eb.e_dstM  = dstM;
    endtask

    task automatic idle();
        set_in(1'b0, 4'h1, 4'h0, 64'h0, 3'b000, 4'hF, 4'hF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_cc_block = 1'b0; m_stall = 1'b0; m_bubble = 1'b0;
        idle();
        repeat (2) step();
        tests++; if (cc !== 3'b100) begin fails++; $display("[TB] FAIL reset_cc got %b want %b", cc, 3'b100); end
        tests++; if (eb.M_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_M_valid got %b want 0", eb.M_valid); end
        tests++; if (eb.M_icode !== 4'h1) begin fails++; $display("[TB] FAIL reset_M_icode got %h want 1", eb.M_icode); end
        tests++; if (eb.M_dstE !== 4'hF || eb.M_dstM !== 4'hF) begin fails++; $display("[TB] FAIL reset_M_dst got %h/%h want F/F", eb.M_dstE, eb.M_dstM); end
        tests++; if (eb.M_valE !== 64'h0) begin fails++; $display("[TB] FAIL reset_M_valE got %h want 0", eb.M_valE); end
        tests++; if (cc_upd_cnt !== 32'h0) begin fails++; $display("[TB] FAIL reset_cnt got %0d want 0", cc_upd_cnt); end
        rst_n = 1'b1;
        upd_applied = 0;
    endtask

    task automatic test_signed_flags();
        set_in(1'b1, 4'h6, 4'h0, 64'h10, 3'b010, 4'h1, 4'hF);
        step(); upd_applied++;
        tests++; if (cc !== 3'b010) begin fails++; $display("[TB] FAIL flags_cc_neg got %b want 010", cc); end
        set_in(1'b1, 4'h7, 4'h2, 64'h0, 3'b000, 4'hF, 4'hF); #1;
        tests++; if (e_cnd !== 1'b1) begin fails++; $display("[TB] FAIL flags_jl_neg got %b want 1", e_cnd); end
        eb.e_ifun = 4'h5; #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_jge_neg got %b want 0", e_cnd); end
        eb.e_ifun = 4'h2; eb.e_valid = 1'b0; #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_invalid got %b want 0", e_cnd); end
        set_in(1'b1, 4'h6, 4'h1, 64'h20, 3'b011, 4'h1, 4'hF);
        step(); upd_applied++;
        tests++; if (cc !== 3'b011) begin fails++; $display("[TB] FAIL flags_cc_ovf got %b want 011", cc); end
        set_in(1'b1, 4'h7, 4'h2, 64'h0, 3'b100, 4'hF, 4'hF); #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_jl_ovf got %b want 0", e_cnd); end
        eb.e_ifun = 4'h5; #1;
        tests++; if (e_cnd !== 1'b1) begin fails++; $display("[TB] FAIL flags_jge_ovf got %b want 1", e_cnd); end
        eb.e_ifun = 4'h1; #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_jle_ovf got %b want 0", e_cnd); end
        eb.e_ifun = 4'h6; #1;
        tests++; if (e_cnd !== 1'b1) begin fails++; $display("[TB] FAIL flags_jg_ovf got %b want 1", e_cnd); end
        eb.e_ifun = 4'h3; #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_je_uses_reg got %b want 0", e_cnd); end
        eb.e_ifun = 4'h9; #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL flags_ifun9 got %b want 0", e_cnd); end
        eb.e_ifun = 4'h0; #1;
        tests++; if (e_cnd !== 1'b1) begin fails++; $display("[TB] FAIL flags_jmp got %b want 1", e_cnd); end
        idle();
    endtask

    task automatic test_cmov();
        set_in(1'b1, 4'h6, 4'h0, 64'h0, 3'b000, 4'h1, 4'hF);
        step(); upd_applied++;
        tests++; if (cc !== 3'b000) begin fails++; $display("[TB] FAIL cmov_cc_clear got %b want 000", cc); end
        set_in(1'b1, 4'h2, 4'h3, 64'h44, 3'b111, 4'h3, 4'hF); #1;
        tests++; if (e_cnd !== 1'b0) begin fails++; $display("[TB] FAIL cmov_cnd_nt got %b want 0", e_cnd); end
        step();
        tests++; if (eb.M_dstE !== 4'hF || eb.M_cnd !== 1'b0) begin fails++; $display("[TB] FAIL cmov_not_taken got dstE=%h cnd=%b want F/0", eb.M_dstE, eb.M_cnd); end
        set_in(1'b1, 4'h6, 4'h0, 64'h0, 3'b100, 4'h1, 4'hF);
        step(); upd_applied++;
        set_in(1'b1, 4'h2, 4'h3, 64'h44, 3'b000, 4'h3, 4'hF);
        step();
        tests++; if (eb.M_dstE !== 4'h3 || eb.M_cnd !== 1'b1 || eb.M_icode !== 4'h2) begin fails++; $display("[TB] FAIL cmov_taken got dstE=%h cnd=%b icode=%h want 3/1/2", eb.M_dstE, eb.M_cnd, eb.M_icode); end
        tests++; if (eb.M_valE !== 64'h44 || eb.M_valA !== 64'hE1) begin fails++; $display("[TB] FAIL cmov_vals got valE=%h valA=%h want 44/e1", eb.M_valE, eb.M_valA); end
        idle();
    endtask

    task automatic test_update_suppression();
        set_cc_block = 1'b1;
        set_in(1'b1, 4'h6, 4'h0, 64'h0, 3'b000, 4'h1, 4'hF);
        step();
        set_cc_block = 1'b0;
        exp_cnt = CNT_EN ? 32'(upd_applied) : 32'h0;
        tests++; if (cc !== 3'b100) begin fails++; $display("[TB] FAIL supp_block_cc got %b want 100", cc); end
        tests++; if (cc_upd_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL supp_block_cnt got %0d want %0d", cc_upd_cnt, exp_cnt); end
        m_stall = 1'b1;
        step();
        m_stall = 1'b0;
        tests++; if (cc !== 3'b100) begin fails++; $display("[TB] FAIL supp_stall_cc got %b want 100", cc); end
        tests++; if (cc_upd_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL supp_stall_cnt got %0d want %0d", cc_upd_cnt, exp_cnt); end
        idle();
        step();
    endtask

    task automatic test_stall_bubble();
        set_in(1'b1, 4'h3, 4'h0, 64'h35, 3'b000, 4'h5, 4'hF);
        step();
        tests++; if (eb.M_valE !== 64'h35 || eb.M_valid !== 1'b1) begin fails++; $display("[TB] FAIL sb_load got valE=%h valid=%b want 35/1", eb.M_valE, eb.M_valid); end
        m_stall = 1'b1;
        eb.alu_out = 64'h99;
        eb.e_dstE = 4'h7;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++; if (eb.M_valE !== 64'h35 || eb.M_dstE !== 4'h5) begin fails++; $display("[TB] FAIL sb_hold%0d got valE=%h dstE=%h want 35/5", i, eb.M_valE, eb.M_dstE); end
        end
        m_bubble = 1'b1;
        step();
        m_stall = 1'b0; m_bubble = 1'b0;
        tests++; if (eb.M_valid !== 1'b0 || eb.M_icode !== 4'h1 || eb.M_cnd !== 1'b0) begin fails++; $display("[TB] FAIL sb_bubble_ctl got valid=%b icode=%h cnd=%b want 0/1/0", eb.M_valid, eb.M_icode, eb.M_cnd); end
        tests++; if (eb.M_valE !== 64'h0 || eb.M_valA !== 64'h0 || eb.M_dstE !== 4'hF || eb.M_dstM !== 4'hF) begin fails++; $display("[TB] FAIL sb_bubble_data got valE=%h valA=%h dstE=%h dstM=%h want 0/0/F/F", eb.M_valE, eb.M_valA, eb.M_dstE, eb.M_dstM); end
        idle();
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 4'h6, 4'h1, 64'h1, 3'b010, 4'h2, 4'hF);
        step(); upd_applied++;
        tests++; if (eb.M_valE !== 64'h1 || eb.M_icode !== 4'h6 || cc !== 3'b010) begin fails++; $display("[TB] FAIL b2b_op got valE=%h icode=%h cc=%b want 1/6/010", eb.M_valE, eb.M_icode, cc); end
        set_in(1'b1, 4'h7, 4'h2, 64'h2, 3'b000, 4'hF, 4'hF); #1;
        tests++; if (e_cnd !== 1'b1) begin fails++; $display("[TB] FAIL b2b_jl got %b want 1", e_cnd); end
        step();
        tests++; if (eb.M_valE !== 64'h2 || eb.M_cnd !== 1'b1 || eb.M_icode !== 4'h7) begin fails++; $display("[TB] FAIL b2b_jxx got valE=%h cnd=%b icode=%h want 2/1/7", eb.M_valE, eb.M_cnd, eb.M_icode); end
        set_in(1'b1, 4'h3, 4'h0, 64'h3, 3'b000, 4'h4, 4'hF);
        step();
        tests++; if (eb.M_valE !== 64'h3 || eb.M_cnd !== 1'b0 || eb.M_dstE !== 4'h4) begin fails++; $display("[TB] FAIL b2b_irmov got valE=%h cnd=%b dstE=%h want 3/0/4", eb.M_valE, eb.M_cnd, eb.M_dstE); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        set_in(1'b1, 4'h6, 4'h0, 64'h0, 3'b011, 4'h1, 4'hF);
        step(); upd_applied++;
        set_in(1'b1, 4'h3, 4'h0, 64'h77, 3'b000, 4'h2, 4'h4);
        step();
        m_stall = 1'b1;
        step();
        tests++; if (eb.M_valE !== 64'h77 || eb.M_valid !== 1'b1) begin fails++; $display("[TB] FAIL rms_hold got valE=%h valid=%b want 77/1", eb.M_valE, eb.M_valid); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (cc !== 3'b100) begin fails++; $display("[TB] FAIL rms_cc got %b want 100", cc); end
        tests++; if (eb.M_valid !== 1'b0 || eb.M_icode !== 4'h1) begin fails++; $display("[TB] FAIL rms_ctl got valid=%b icode=%h want 0/1", eb.M_valid, eb.M_icode); end
        tests++; if (eb.M_dstE !== 4'hF || eb.M_dstM !== 4'hF || eb.M_valE !== 64'h0) begin fails++; $display("[TB] FAIL rms_data got dstE=%h dstM=%h valE=%h want F/F/0", eb.M_dstE, eb.M_dstM, eb.M_valE); end
        tests++; if (cc_upd_cnt !== 32'h0) begin fails++; $display("[TB] FAIL rms_cnt got %0d want 0", cc_upd_cnt); end
        m_stall = 1'b0;
        idle();
        step();
        rst_n = 1'b1;
        upd_applied = 0;
    endtask

    task automatic test_counter();
        logic [2:0] seq [5];
        seq = '{3'b001, 3'b010, 3'b111, 3'b000, 3'b110};
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 4'h6, 4'h0, 64'(i), seq[i], 4'h1, 4'hF);
            set_cc_block = (i == 2);
            step();
            if (i != 2) upd_applied++;
        end
        set_cc_block = 1'b0;
        idle();
        step();
        exp_cnt = CNT_EN ? 32'(upd_applied) : 32'h0;
        tests++; if (cc !== 3'b110) begin fails++; $display("[TB] FAIL cnt_cc got %b want 110", cc); end
        tests++; if (cc_upd_cnt !== exp_cnt) begin fails++; $display("[TB] FAIL cnt_value got %0d want %0d", cc_upd_cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_signed_flags();
        test_cmov();
        test_update_suppression();
        test_stall_bubble();
        test_back_to_back();
        test_reset_mid_stall();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/execute_cc_stage.md
# execute_cc_stage

Execute-stage back end for the Y86-64 pipeline, directly downstream of the ALU. It latches the ALU condition codes `{ZF,SF,OF}` into the architectural CC register and evaluates jump and conditional-move conditions against that register. It also registers execute results into the E→M pipeline register with stall and bubble control.

## Interface
Parameters:
- `W`, 64, datapath width (matches ALU `out`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `e_valid`  in  1  execute stage holds a real instruction.
- `e_icode`  in  4  instruction code.
- `e_ifun`  in  4  function code (ALU op or condition selector).
- `alu_out`  in  W  ALU result (valE).
- `alu_cc`  in  3  ALU flags `{ZF,SF,OF}`.
- `e_valA`  in  W  forwarded valA.
- `e_dstE`, `e_dstM`  in  4 each  destination register IDs (`4'hF` = none).
- `set_cc_block`  in  1  suppress CC update (exception downstream).
- `m_stall`  in  1  hold the M register.
- `m_bubble`  in  1  inject a nop into the M register.
- `cc`  out  3  architectural CC register `{ZF,SF,OF}`.
- `e_cnd`  out  1  condition result for the current instruction.
- `M_valid`, `M_icode`, `M_cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM`  out  1/4/1/W/W/4/4  E→M pipeline register.
- `cc_upd_cnt`  out  32  CC update counter (see Configuration).

## Operation
CC register:
- Update condition: `e_valid && e_icode==4'h6` (OPq), `!set_cc_block`, and `!m_stall`. On update, `cc <= alu_cc`.
- When the update condition is false, `cc` holds its value.
- Reset value is `3'b100` (ZF=1, SF=0, OF=0).

Condition evaluation:
- `e_cnd` is combinational from the current `cc` register and `e_ifun`. It uses flags set by earlier instructions, never by `alu_cc` in the same cycle.
- Conditions by `e_ifun`:
  - 0 always: 1
  - 1 le: `(SF^OF)|ZF`
  - 2 l: `SF^OF`
  - 3 e: `ZF`
  - 4 ne: `!ZF`
  - 5 ge: `!(SF^OF)`
  - 6 g: `!(SF^OF)&!ZF`
  - 7–15: 0
- `e_cnd` is forced to 0 unless `e_valid` is high and `e_icode` is 2 (rrmovq/cmovXX) or 7 (jXX).

M register load selection (priority: reset > bubble > stall > load):
- Bubble: `M_valid=0`, `M_icode=4'h1`, `M_cnd=0`, `M_valE=0`, `M_valA=0`, `M_dstE=M_dstM=4'hF`. Bubble wins over a simultaneous stall.
- Stall: all M outputs hold their values.
- Load: `M_valid=e_valid`, `M_icode=e_icode`, `M_cnd=e_cnd`, `M_valE=alu_out`, `M_valA=e_valA`, `M_dstM=e_dstM`.
  - `M_dstE=4'hF` when `e_icode==2 && !e_cnd` (cmov not taken); otherwise `e_dstE`.
- Invalid inputs (`e_valid=0`) load as-is; no CC update occurs.

## Timing
- `e_cnd` has zero latency: it is combinational and settles within the same cycle.
- A CC update is visible on `cc` one cycle after the OPq is in execute. The next instruction's `e_cnd` uses it.
- M outputs have one cycle of latency from the E inputs.
- Reset: asserting `rst_n` low at any time immediately forces all outputs to bubble values, `cc=3'b100`, and `cc_upd_cnt=0`, including mid-stall.
- Reset deassertion is synchronous to the design (the external reset synchronizer is responsible).

## Configuration
- `CC_UPD_CNT_EN` defined:
  - `cc_upd_cnt` increments by 1 on every cycle where the CC update condition is true.
  - It saturates at `32'hFFFF_FFFF` and clears only on reset.
- `CC_UPD_CNT_EN` undefined:
  - The counter is not built.
  - `cc_upd_cnt` is tied to `32'h0`.

## Test plan
- Reset mid-stall: with `m_stall=1` holding valid data, pulse `rst_n` low. Expect `cc=3'b100`, `M_valid=0`, `M_icode=4'h1`, `M_dstE=M_dstM=4'hF`, and `cc_upd_cnt=0` immediately.
- Signed flags: apply OPq with `alu_cc=3'b010`, then jXX with `ifun=2`. Expect `e_cnd=1`; with `ifun=5`, expect `e_cnd=0`. Then apply OPq with `alu_cc=3'b011` (overflow). Expect jl → 0 and jge → 1.
- cmov: with `cc=3'b000`, apply `icode=2, ifun=3, e_dstE=4'h3`. Expect `M_dstE=4'hF`. After an OPq with `alu_cc=3'b100`, the same input gives `M_dstE=4'h3`.
- Update suppression: apply OPq with `alu_cc=3'b000` and `set_cc_block=1`. Expect `cc` to stay `3'b100` and the counter to be unchanged. Repeat with `m_stall=1`: `cc` is unchanged.
- Stall/bubble: load `alu_out=64'h35`, then hold `m_stall=1` for 2 cycles. Expect `M_valE=64'h35` throughout. Assert `m_stall=1` and `m_bubble=1` together. Expect bubble values next cycle.
- Counter (`CC_UPD_CNT_EN` defined): apply 5 valid OPq cycles, 1 of them with `set_cc_block`. Expect `cc_upd_cnt=4`. With the macro undefined, expect 0.
